// File: rtl/cmd_pkg.sv
// Shared types and helpers for the cmd_if responder: FSM state encoding,
// bytes-per-beat derivation and the partial-beat byte-enable mask.
package cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } cmd_resp_state_t;

   // Widest beat the mask helper supports (DATAW up to 1024).
   localparam int MAX_BPB = 128;

   function automatic int bpb_of(input int dataw);
      return dataw / 8;
   endfunction

   // Low min(rem, bpb) bits set; callers truncate to their own beat width.
   function automatic logic [MAX_BPB-1:0] be_mask(input int unsigned rem,
                                                  input int unsigned bpb);
      logic [MAX_BPB-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_BPB; i++) begin
         m[i] = (i < rem) && (i < bpb);
      end
      return m;
   endfunction

endpackage

// File: rtl/cmd_rd_fifo.sv
// Two-entry read-return FIFO with a registered head; count feeds the
// responder's read-credit check.
module cmd_rd_fifo #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         vld,
   output logic [1:0]   count
);

   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic [1:0]   count_q;
   logic         do_pop;
   logic         do_push;

   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   // NOTE: the two data slots are reset too, so rdata reads 0 out of reset;
   // larger storage arrays would normally be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         case (count_q)
            2'd0: begin
               if (do_push) begin
                  head_q  <= din;
                  count_q <= 2'd1;
               end
            end
            2'd1: begin
               if (do_push && do_pop) begin
                  head_q <= din;
               end else if (do_push) begin
                  tail_q  <= din;
                  count_q <= 2'd2;
               end else if (do_pop) begin
                  count_q <= 2'd0;
               end
            end
            default: begin
               if (do_pop) begin
                  head_q <= tail_q;
                  if (do_push) tail_q <= din;
                  else         count_q <= 2'd1;
               end
            end
         endcase
      end
   end

   assign dout  = head_q;
   assign vld   = (count_q != 2'd0);
   assign count = count_q;

endmodule

// File: rtl/cmd_resp.sv
// Responder end of cmd_if: acks one chunk command and runs it as a word burst
// against a synchronous single-port memory. Define CMD_RESP_ERR_EN for err.
module cmd_resp
   import cmd_pkg::*;
#(
   parameter int ADDRW     = 32,
   parameter int BYTE_CNTW = 16,
   parameter int DATAW     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic                 wr,
   input  logic [BYTE_CNTW-1:0] byte_cnt,
   input  logic [ADDRW-1:0]     start_addr,
   output logic                 req_ack,
   output logic                 done,
   input  logic                 wdata_vld,
   output logic                 wdata_rdy,
   input  logic [DATAW-1:0]     wdata,
   output logic                 rdata_vld,
   input  logic                 rdata_rdy,
   output logic [DATAW-1:0]     rdata,
   output logic                 rdata_last,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDRW-1:0]     mem_addr,
   output logic [DATAW/8-1:0]   mem_be,
   output logic [DATAW-1:0]     mem_wdata,
`ifdef CMD_RESP_ERR_EN
   output logic                 err,
`endif
   input  logic [DATAW-1:0]     mem_rdata
);

   localparam int                   BPB      = bpb_of(DATAW);
   localparam logic [BYTE_CNTW-1:0] BPB_CNT  = BYTE_CNTW'(BPB);
   localparam logic [ADDRW-1:0]     BPB_ADDR = ADDRW'(BPB);
   localparam logic [ADDRW-1:0]     LSB_MASK = ADDRW'(BPB - 1);

   cmd_resp_state_t      state;
   logic [ADDRW-1:0]     addr;
   logic [BYTE_CNTW-1:0] rem;
   logic [BYTE_CNTW-1:0] step;
   logic                 rem_le_bpb;
   logic                 inflight;
   logic                 inflight_last;
   logic                 wr_fire;
   logic                 rd_issue;
   logic                 rd_pop;
   logic [1:0]           fifo_cnt;
   logic [2:0]           occ;
   logic [DATAW:0]       fifo_dout;
`ifdef CMD_RESP_ERR_EN
   logic                 bad;
`endif

   assign wdata_rdy  = (state == WRITE);
   assign rem_le_bpb = (rem <= BPB_CNT);
   assign step       = rem_le_bpb ? rem : BPB_CNT;
   assign wr_fire    = wdata_rdy && wdata_vld;
   assign rd_pop     = rdata_vld && rdata_rdy;

   // Credit: buffered + in flight, less what leaves this cycle, must stay < 2.
   assign occ      = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, rd_pop};
   assign rd_issue = (state == READ) && (rem != '0) && (occ < 3'd2);

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      mem_en    = wr_fire || rd_issue;
      mem_we    = wr_fire;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (mem_en) mem_addr = addr & ~LSB_MASK;
      if (wr_fire) begin
         mem_wdata = wdata;
         mem_be    = BPB'(be_mask(32'(rem), BPB));
      end
   end

   cmd_rd_fifo #(.W(DATAW + 1)) u_rd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   ({inflight_last, mem_rdata}),
      .pop   (rd_pop),
      .dout  (fifo_dout),
      .vld   (rdata_vld),
      .count (fifo_cnt)
   );

   assign rdata      = fifo_dout[DATAW-1:0];
   assign rdata_last = rdata_vld && fifo_dout[DATAW];

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         addr          <= '0;
         rem           <= '0;
         req_ack       <= 1'b0;
         done          <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
`ifdef CMD_RESP_ERR_EN
         err           <= 1'b0;
         bad           <= 1'b0;
`endif
      end else begin
         req_ack       <= 1'b0;
         inflight      <= rd_issue;
         inflight_last <= rd_issue && rem_le_bpb;
         case (state)
            IDLE: begin
               if (req) begin
                  req_ack <= 1'b1;
                  addr    <= start_addr & ~LSB_MASK;
                  rem     <= byte_cnt;
`ifdef CMD_RESP_ERR_EN
                  bad     <= (start_addr & LSB_MASK) != '0;
                  if ((byte_cnt == '0) || ((start_addr & LSB_MASK) != '0))
                     state <= DONE;
`else
                  if (byte_cnt == '0)
                     state <= DONE;
`endif
                  else
                     state <= wr ? WRITE : READ;
               end
            end
            WRITE: begin
               if (wr_fire) begin
                  addr <= addr + BPB_ADDR;
                  rem  <= rem - step;
                  if (rem_le_bpb) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (rd_issue) begin
                  addr <= addr + BPB_ADDR;
                  rem  <= rem - step;
               end
               if (rd_pop && rdata_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               // Bursts arrive with done already set; empty/rejected
               // commands spend one cycle here before raising it.
               if (done) begin
                  done  <= 1'b0;
                  state <= IDLE;
`ifdef CMD_RESP_ERR_EN
                  err   <= 1'b0;
`endif
               end else begin
                  done  <= 1'b1;
`ifdef CMD_RESP_ERR_EN
                  err   <= bad;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_resp.sv
// Randomised scoreboard bench for cmd_resp with a behavioural memory and
// stream reference model.
module tb_cmd_resp;

   localparam int BPB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        wr;
   logic [15:0] byte_cnt;
   logic [31:0] start_addr;
   logic        req_ack;
   logic        done;
   logic        wdata_vld;
   logic        wdata_rdy;
   logic [31:0] wdata;
   logic        rdata_vld;
   logic        rdata_rdy;
   logic [31:0] rdata;
   logic        rdata_last;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef CMD_RESP_ERR_EN
   logic        err;
`endif

   cmd_resp dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .wr         (wr),
      .byte_cnt   (byte_cnt),
      .start_addr (start_addr),
      .req_ack    (req_ack),
      .done       (done),
      .wdata_vld  (wdata_vld),
      .wdata_rdy  (wdata_rdy),
      .wdata      (wdata),
      .rdata_vld  (rdata_vld),
      .rdata_rdy  (rdata_rdy),
      .rdata      (rdata),
      .rdata_last (rdata_last),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
`ifdef CMD_RESP_ERR_EN
      .err        (err),
`endif
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory content model; unwritten words return an address-derived pattern.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {~a[15:0], a[15:0]};
   endfunction

   logic        rd_pend = 1'b0;
   logic [31:0] rd_buf  = '0;

   always @(negedge clk) begin
      logic [31:0] w;
      rd_pend = 1'b0;
      if (rst && mem_en) begin
         if (mem_we) begin
            w = mem_word(mem_addr);
            for (int b = 0; b < BPB; b++)
               if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr] = w;
         end else begin
            rd_pend = 1'b1;
            rd_buf  = mem_word(mem_addr);
         end
      end
   end

   always @(posedge clk) if (rd_pend) mem_rdata <= rd_buf;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } rd_t;

   wr_t         exp_wr[$];
   rd_t         exp_rd[$];
   logic [31:0] exp_ra[$];

   int rd_issued = 0;
   int rd_popped = 0;
   int max_out = 0;
   int mem_en_cnt = 0;
   int last_wr_cyc = 0;
   int last_rd_cyc = 0;

   // Monitor: pops expectations whenever the DUT presents a transaction.
   always @(negedge clk) begin
      wr_t e;
      rd_t r;
      logic [31:0] ra;
      if (!rst) begin
         rd_issued = 0;
         rd_popped = 0;
      end else begin
         if (mem_en) mem_en_cnt++;
         if (mem_en && mem_we) begin
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write: got addr %0h, expected no write", mem_addr);
            end else begin
               e = exp_wr.pop_front();
               check("mem_write", 72'({mem_addr, mem_be, mem_wdata}), 72'(e));
            end
         end
         if (mem_en && !mem_we) begin
            rd_issued++;
            if (exp_ra.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: got addr %0h, expected no read", mem_addr);
            end else begin
               ra = exp_ra.pop_front();
               check("mem_rd_addr", 72'(mem_addr), 72'(ra));
            end
         end
         if (rdata_vld && rdata_rdy) begin
            rd_popped++;
            if (rdata_last) last_rd_cyc = cyc;
            if (exp_rd.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rdata: got %0h, expected no beat", rdata);
            end else begin
               r = exp_rd.pop_front();
               check("rdata_beat", 72'({rdata_last, rdata}), 72'(r));
            end
         end
         if (rd_issued - rd_popped > max_out) max_out = rd_issued - rd_popped;
      end
   end

   task automatic drive_streams(input logic w, input int beats, input int idx,
                                input logic [31:0] nxt, input int vmode, input int rmode);
      wdata_vld = w && (idx < beats) && ((vmode == 0) || ($urandom_range(0, 1) == 1));
      wdata     = nxt;
      case (rmode)
         0:       rdata_rdy = 1'b1;
         1:       rdata_rdy = cyc[0];
         default: rdata_rdy = ($urandom_range(0, 1) == 1);
      endcase
   endtask

   // vmode: 0 wdata always valid, 1 random. rmode: 0 always ready, 1 toggle, 2 random.
   task automatic run_cmd(input logic w, input int bc, input logic [31:0] a,
                          input int vmode, input int rmode);
      int          beats;
      logic [31:0] base;
      logic [31:0] words[$];
      logic        bad_align;
      int          c0, en0, idx, rem_i;
      int          ack_cyc, done_cyc, first_rd;
      wr_t         e;
      rd_t         r;
      logic [31:0] ad;
`ifdef CMD_RESP_ERR_EN
      bad_align = (a[1:0] != 2'b00);
`else
      bad_align = 1'b0;
`endif
      base  = a & ~32'h3;
      beats = bad_align ? 0 : (bc + BPB - 1) / BPB;
      for (int i = 0; i < beats; i++) begin
         ad    = base + 32'(i * BPB);
         rem_i = bc - i * BPB;
         if (w) begin
            e.addr = ad;
            e.be   = (rem_i >= BPB) ? 4'hF : 4'((1 << rem_i) - 1);
            e.data = $urandom;
            words.push_back(e.data);
            exp_wr.push_back(e);
         end else begin
            r.last = (i == beats - 1);
            r.data = mem_word(ad);
            exp_ra.push_back(ad);
            exp_rd.push_back(r);
         end
      end
      idx = 0; ack_cyc = -1; done_cyc = -1; first_rd = -1;
      max_out = 0;
      en0 = mem_en_cnt;

      @(posedge clk); #1;
      c0 = cyc;
      req = 1'b1; wr = w; byte_cnt = 16'(bc); start_addr = a;
      drive_streams(w, beats, idx, (beats > 0) ? words[0] : 32'h0, vmode, rmode);
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (req_ack && ack_cyc < 0) ack_cyc = cyc;
         if (wdata_vld && wdata_rdy) idx++;
         if (rdata_vld && rdata_rdy && first_rd < 0) first_rd = cyc;
         if (done) begin
            done_cyc = cyc;
`ifdef CMD_RESP_ERR_EN
            check("err_at_done", 72'(err), 72'(bad_align));
`endif
            break;
         end
         @(posedge clk); #1;
         if (ack_cyc >= 0) req = 1'b0;
         drive_streams(w, beats, idx, (idx < beats) ? words[idx] : 32'h0, vmode, rmode);
      end
      @(posedge clk); #1;
      req = 1'b0; wdata_vld = 1'b0; rdata_rdy = 1'b0;

      check("done_seen", 72'(done_cyc >= 0), 72'(1));
      check("ack_latency", 72'(ack_cyc - c0), 72'(1));
      if (bc == 0 || bad_align) begin
         check("empty_done_latency", 72'(done_cyc - c0), 72'(2));
         check("no_mem_access", 72'(mem_en_cnt - en0), 72'(0));
      end else if (w) begin
         check("wr_done_latency", 72'(done_cyc - last_wr_cyc), 72'(1));
      end else begin
         check("rd_done_latency", 72'(done_cyc - last_rd_cyc), 72'(1));
         check("rd_outstanding_le2", 72'(max_out <= 2), 72'(1));
         if (rmode == 0) begin
            check("rd_first_latency", 72'(first_rd - c0), 72'(3));
            check("rd_throughput", 72'(last_rd_cyc - first_rd), 72'(beats - 1));
         end
      end
      check("queues_drained", 72'(exp_wr.size() + exp_rd.size() + exp_ra.size()), 72'(0));
      exp_wr.delete(); exp_rd.delete(); exp_ra.delete();
   endtask

   task automatic reset_mid_read();
      rd_t r;
      int  hs;
      for (int i = 0; i < 8; i++) begin
         r.last = (i == 7);
         r.data = mem_word(32'h200 + 32'(i * BPB));
         exp_ra.push_back(32'h200 + 32'(i * BPB));
         exp_rd.push_back(r);
      end
      @(posedge clk); #1;
      req = 1'b1; wr = 1'b0; byte_cnt = 16'd32; start_addr = 32'h200; rdata_rdy = 1'b1;
      hs = 0;
      for (int t = 0; t < 100 && hs < 2; t++) begin
         @(negedge clk);
         if (req_ack) req = 1'b0;
         if (rdata_vld && rdata_rdy) hs++;
      end
      check("reset_test_two_beats", 72'(hs), 72'(2));
      #1 rst = 1'b0;
      req = 1'b0; rdata_rdy = 1'b0;
      #1;
      check("rst_ctrl_outputs", 72'({req_ack, done, rdata_vld, rdata_last, mem_en, mem_we, wdata_rdy}), 72'(0));
      check("rst_rdata", 72'(rdata), 72'(0));
      check("rst_mem_addr_be", 72'({mem_addr, mem_be}), 72'(0));
      exp_rd.delete(); exp_ra.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_held_rdata_vld", 72'(rdata_vld), 72'(0));
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; req = 1'b0; wr = 1'b0; byte_cnt = '0; start_addr = '0;
      wdata_vld = 1'b0; wdata = '0; rdata_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl_outputs", 72'({req_ack, done, rdata_vld, rdata_last, mem_en, wdata_rdy}), 72'(0));
      check("reset_data_outputs", 72'({rdata, mem_be}), 72'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      run_cmd(1'b1, 10,  32'h100, 0, 0);
      run_cmd(1'b0, 12,  32'h100, 0, 0);
      run_cmd(1'b0, 512, 32'h0,   0, 0);
      run_cmd(1'b0, 16,  32'h100, 0, 1);
      run_cmd(1'b1, 0,   32'h40,  0, 0);
      run_cmd(1'b0, 0,   32'h40,  0, 0);
      run_cmd(1'b1, 16,  32'hFFFF_FFF8, 1, 0);
      run_cmd(1'b0, 16,  32'hFFFF_FFF8, 0, 2);
      run_cmd(1'b1, 7,   32'h302, 0, 0);
      reset_mid_read();
      run_cmd(1'b1, 9,   32'h500, 0, 0);
      run_cmd(1'b0, 9,   32'h500, 0, 2);

      for (int n = 0; n < 30; n++) begin
         run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
                 32'($urandom_range(0, 1023)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
